control_cuenta1: RTL and testbench
==================================

# control_cuenta1

Sequencer that drives the `cuenta1` counting stage through a sweep of input values and collects its results. On a `go` pulse it presents `N_VAL` consecutive 3-bit values on `Valor`. For each value it runs a four-phase `start`/`Fin` handshake, captures `Cuenta`, and accumulates the sum and the maximum of all results. It sits directly upstream and downstream of `cuenta1`, replacing manual stimulus with a self-checking hardware sweep.

## Interface
- `N_VAL`, 8 — number of values per sweep (1..8).
- `TIMEOUT`, 64 — max cycles spent waiting for each `Fin` edge before aborting (≥2).
- `clk` in 1 — single clock, rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `go` in 1 — start-sweep request, sampled only in IDLE/DONE/ERR.
- `first` in 3 — first value of the sweep, sampled when `go` is accepted.
- `Valor` out 3 — value presented to `cuenta1`.
- `start` out 1 — request to `cuenta1`.
- `Cuenta` in 4 — result from `cuenta1`, valid while `Fin`=1.
- `Fin` in 1 — completion flag from `cuenta1`.
- `busy` out 1 — sweep in progress.
- `done` out 1 — sweep completed without error (level, held until next `go`).
- `error` out 1 — timeout abort (level, held until next `go`).
- `suma` out 7 — sum of captured `Cuenta` values.
- `maximo` out 4 — largest captured `Cuenta`.
- `n_ok` out 4 — number of results captured in the current/last sweep.

## Operation
- **Reset values:** state IDLE; `Valor`=0, `start`=0, `busy`=0, `done`=0, `error`=0, `suma`=0, `maximo`=0, `n_ok`=0; timeout counter=0.
- **States:** IDLE, REQ, CAPT, REL, NEXT, DONE, ERR.
- **IDLE/DONE/ERR + `go`=1:**
  - `Valor`←`first`; clear `suma`, `maximo`, `n_ok`, `done`, `error`.
  - `busy`←1, go to REQ.
  - `go` in any other state is ignored.
- **REQ:**
  - `start`=1.
  - `Fin`=1 → CAPT.
  - Otherwise increment timeout; on reaching `TIMEOUT` → ERR.
- **CAPT (one cycle):**
  - `suma`←`suma`+`Cuenta` (7-bit, max 8×15=120, no overflow).
  - `maximo`←max(`maximo`,`Cuenta`); `n_ok`←`n_ok`+1.
  - `start`←0, clear timeout, go to REL.
- **REL:**
  - `start`=0.
  - `Fin`=0 → NEXT.
  - Otherwise timeout as in REQ → ERR.
- **NEXT (one cycle):**
  - If `n_ok`==`N_VAL` → DONE.
  - Else `Valor`←`Valor`+1, wrapping mod 8 (7→0), and go to REQ.
- **DONE:** `busy`=0, `done`=1.
- **ERR:**
  - `busy`=0, `error`=1, `start`=0.
  - Accumulators keep the values from before the abort.
- `Valor` is stable for the whole handshake of one value and changes only in NEXT, while `start`=0.
- `Fin` already 1 on REQ entry is accepted immediately; no edge detection is used.
- An async reset mid-sweep returns to reset values at once; `start` drops without waiting for `Fin`.

## Timing
- `go` accepted at edge k: `Valor`=`first`, `start`=1, `busy`=1 from k+1.
- `Fin` sampled 1 in REQ at edge m:
  - CAPT during cycle m+1; accumulators and `start`=0 visible from edge m+2.
- `Fin` sampled 0 in REL at edge r: NEXT in cycle r+1; new `Valor` and `start`=1 from edge r+2.
- Minimum per value with instant `Fin` response: 4 cycles (REQ, CAPT, REL, NEXT).
- `done`/`error` rise on the edge that enters DONE/ERR; `busy` falls on the same edge.
- Timeout: ERR entered on the `TIMEOUT`-th consecutive cycle waiting in REQ or REL.

## Test plan
- **Basic sweep:**
  - Stimulus: `first`=0, `N_VAL`=8; model answers `Fin`=1 three cycles after `start` with `Cuenta`=`Valor`+1.
  - Required: `Valor` steps 0..7, `suma`=36, `maximo`=8, `n_ok`=8, `done`=1, `error`=0.
- **Wrap-around:**
  - Stimulus: `first`=6, `N_VAL`=4, `Cuenta`=`Valor`.
  - Required: `Valor` sequence 6,7,0,1; `suma`=14, `maximo`=7.
- **Timeout in REQ:**
  - Stimulus: model never raises `Fin`, `TIMEOUT`=64.
  - Required: `error`=1 exactly 64 cycles after `start` rises; `start`=0, `n_ok`=0, `done`=0.
- **Timeout in REL:**
  - Stimulus: `Fin` stuck at 1 after the first capture.
  - Required: `error`=1, `n_ok`=1, `suma` = first `Cuenta`.
- **Immediate `Fin` and ignored `go`:**
  - Stimulus: `Fin` held 1 with `Cuenta`=15, `N_VAL`=8; pulse `go` mid-sweep.
  - Required: sweep completes unchanged, `suma`=120, `maximo`=15.
  - Note: if `Fin` is held 1 throughout, the sweep times out in REL and `error`=1.
- **Reset mid-sweep:**
  - Stimulus: drop `rst_n` asynchronously in REQ.
  - Required: all outputs return to reset values before the next clock edge; a new `go` after release sweeps correctly.

Source files
------------

// File: rtl/control_cuenta1.sv
// control_cuenta1 -- sweep sequencer for the cuenta1 counting stage.
//
// On an accepted `go` it presents N_VAL consecutive 3-bit values on `Valor`
// (starting at `first`, wrapping 7->0). For each value it runs a four-phase
// start/Fin handshake, captures `Cuenta` while Fin=1, and accumulates the
// sum and maximum of the results. A wait longer than TIMEOUT cycles for
// either Fin edge aborts the sweep into ERR.
//
// Handshake: start is raised with Valor already stable. cuenta1 answers by
// raising Fin with Cuenta valid. We capture, drop start, and wait for Fin to
// fall before Valor is allowed to change. Fin already high on entry to REQ
// counts as an answer (level sensitive, no edge detection).
//
// Parameters
//   N_VAL    values per sweep (1..8)
//   TIMEOUT  max cycles waiting for each Fin edge (>=2)
// Ports
//   clk, rst_n      clock (rising edge), async active-low reset
//   go, first       sweep request and first value (sampled in IDLE/DONE/ERR)
//   Valor, start    value and request towards cuenta1
//   Cuenta, Fin     result and completion flag from cuenta1
//   busy            sweep in progress
//   done, error     sweep result levels, held until the next accepted go
//   suma, maximo    sum and maximum of captured results
//   n_ok            number of results captured
//   dbg_state       current FSM state encoding (debug)
module control_cuenta1 #(
  parameter int N_VAL   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       go,
  input  logic [2:0] first,
  output logic [2:0] Valor,
  output logic       start,
  input  logic [3:0] Cuenta,
  input  logic       Fin,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [6:0] suma,
  output logic [3:0] maximo,
  output logic [3:0] n_ok,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_CAPT = 3'd2,
    S_REL  = 3'd3,
    S_NEXT = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMR_ONE  = TW'(1);
  localparam logic [3:0]    N_LAST   = 4'(N_VAL);

  state_t state, state_nxt;
  logic [TW-1:0] tmr;

  // control strobes decoded from the state
  logic launch;   // go accepted
  logic capt;     // capture Cuenta this cycle
  logic waiting;  // waiting for a Fin edge
  logic abort;    // last allowed wait cycle expired
  logic advance;  // move to the next value
  logic finish;   // last value handled

  assign dbg_state = state;

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE, S_ERR: if (go) state_nxt = S_REQ;
      S_REQ: begin
        if (Fin)                  state_nxt = S_CAPT;
        else if (tmr == TMR_LAST) state_nxt = S_ERR;
      end
      S_CAPT: state_nxt = S_REL;
      S_REL: begin
        if (!Fin)                 state_nxt = S_NEXT;
        else if (tmr == TMR_LAST) state_nxt = S_ERR;
      end
      S_NEXT: state_nxt = (n_ok == N_LAST) ? S_DONE : S_REQ;
      default: state_nxt = S_IDLE;
    endcase
  end

  // output / control decode
  always_comb begin
    launch  = 1'b0;
    capt    = 1'b0;
    waiting = 1'b0;
    advance = 1'b0;
    finish  = 1'b0;
    case (state)
      S_IDLE, S_DONE, S_ERR: launch = go;
      S_REQ:  waiting = !Fin;
      S_CAPT: capt = 1'b1;
      S_REL:  waiting = Fin;
      S_NEXT: begin
        finish  = (n_ok == N_LAST);
        advance = (n_ok != N_LAST);
      end
      default: ;
    endcase
    abort = waiting && (tmr == TMR_LAST);
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr    <= '0;
      Valor  <= 3'd0;
      start  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      error  <= 1'b0;
      suma   <= 7'd0;
      maximo <= 4'd0;
      n_ok   <= 4'd0;
    end else begin
      // the wait counter restarts at every handshake phase change
      if (launch || capt || advance || abort) tmr <= '0;
      else if (waiting)                       tmr <= tmr + TMR_ONE;

      if (launch) begin
        Valor  <= first;
        start  <= 1'b1;
        busy   <= 1'b1;
        done   <= 1'b0;
        error  <= 1'b0;
        suma   <= 7'd0;
        maximo <= 4'd0;
        n_ok   <= 4'd0;
      end

      if (capt) begin
        // 8 x 15 = 120 fits in 7 bits
        suma   <= suma + {3'b000, Cuenta};
        if (Cuenta > maximo) maximo <= Cuenta;
        n_ok   <= n_ok + 4'd1;
        start  <= 1'b0;
      end

      // Valor only moves here, with start already low
      if (advance) begin
        Valor <= Valor + 3'd1;
        start <= 1'b1;
      end

      if (finish) begin
        busy <= 1'b0;
        done <= 1'b1;
      end

      if (abort) begin
        busy  <= 1'b0;
        error <= 1'b1;
        start <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_control_cuenta1.sv
// Testbench for control_cuenta1. A behavioural cuenta1 responder answers the
// handshake in several modes; sweep results are checked against a table of
// hand-computed vectors, and the Valor sequence against an expected queue.
module tb_control_cuenta1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // ---------------- DUT (N_VAL=8) ----------------
  logic       go;
  logic [2:0] first;
  logic [2:0] valor;
  logic       start;
  logic [3:0] cuenta = 4'd0;
  logic       fin = 1'b0;
  logic       busy, done, error;
  logic [6:0] suma;
  logic [3:0] maximo, n_ok;
  logic [2:0] dbg;

  control_cuenta1 #(.N_VAL(8), .TIMEOUT(64)) u8 (
    .clk(clk), .rst_n(rst_n), .go(go), .first(first),
    .Valor(valor), .start(start), .Cuenta(cuenta), .Fin(fin),
    .busy(busy), .done(done), .error(error),
    .suma(suma), .maximo(maximo), .n_ok(n_ok), .dbg_state(dbg)
  );

  // ---------------- DUT (N_VAL=4) ----------------
  logic       go4;
  logic [2:0] first4;
  logic [2:0] valor4;
  logic       start4;
  logic [3:0] cuenta4 = 4'd0;
  logic       fin4 = 1'b0;
  logic       busy4, done4, error4;
  logic [6:0] suma4;
  logic [3:0] maximo4, n_ok4;
  logic [2:0] dbg4;

  control_cuenta1 #(.N_VAL(4), .TIMEOUT(64)) u4 (
    .clk(clk), .rst_n(rst_n), .go(go4), .first(first4),
    .Valor(valor4), .start(start4), .Cuenta(cuenta4), .Fin(fin4),
    .busy(busy4), .done(done4), .error(error4),
    .suma(suma4), .maximo(maximo4), .n_ok(n_ok4), .dbg_state(dbg4)
  );

  // ---------------- responder models ----------------
  localparam int M_DELAY = 0;  // Fin 3 cycles after start, drops with start
  localparam int M_IMMED = 1;  // Fin follows start one cycle later
  localparam int M_NEVER = 2;  // Fin never rises
  localparam int M_HIGH  = 3;  // Fin stuck at 1
  localparam int M_STUCK = 4;  // like DELAY, but Fin never falls once raised

  int mode = M_DELAY;
  int cfun = 0;  // 0: Valor+1, 1: Valor, 2: 15
  int dly  = 0;

  function automatic logic [3:0] cfn(input int f, input logic [2:0] v);
    case (f)
      0:       return {1'b0, v} + 4'd1;
      1:       return {1'b0, v};
      default: return 4'd15;
    endcase
  endfunction

  always @(posedge clk) begin
    #1;
    if (start) begin
      if (dly < 3) dly = dly + 1;
    end else begin
      dly = 0;
    end
    case (mode)
      M_IMMED: fin = start;
      M_NEVER: fin = 1'b0;
      M_HIGH:  fin = 1'b1;
      M_STUCK: fin = (fin && busy) || (dly >= 3);
      default: fin = (dly >= 3);
    endcase
    cuenta = cfn(cfun, valor);
  end

  always @(posedge clk) begin
    #1;
    fin4    = start4;
    cuenta4 = {1'b0, valor4};
  end

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] exp_q[$];
  logic [2:0] exp4_q[$];
  logic start_q  = 1'b0;
  logic start4_q = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // each rising start must present the next expected Valor
  always @(negedge clk) begin
    if (start && !start_q) begin
      if (exp_q.size() == 0) check("valor_extra_start", 1, 0);
      else                   check("valor_seq", int'(valor), int'(exp_q.pop_front()));
    end
    start_q = start;
    if (start4 && !start4_q) begin
      if (exp4_q.size() == 0) check("valor4_extra_start", 1, 0);
      else                    check("valor4_seq", int'(valor4), int'(exp4_q.pop_front()));
    end
    start4_q = start4;
  end

  // ---------------- vectors ----------------
  typedef struct {
    logic [2:0] first;
    int         mode;
    int         cfun;
    bit         go_mid;
    int         suma;
    int         maximo;
    int         nok;
    bit         done;
    bit         err;
  } vec_t;

  vec_t vecs[8];

  // ---------------- driver tasks ----------------
  task automatic pulse_go(input logic [2:0] f, input string tag);
    @(negedge clk);
    first = f;
    go    = 1'b1;
    @(negedge clk);
    go = 1'b0;
    check({tag, "_start_lat"}, int'(start), 1);
    check({tag, "_busy_lat"}, int'(busy), 1);
    check({tag, "_valor_lat"}, int'(valor), int'(f));
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_sweep_ends"}, int'(busy), 0);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string tag;
    logic [2:0] e;
    int np;
    tag  = $sformatf("v%0d", idx);
    mode = v.mode;
    cfun = v.cfun;
    np = (v.nok == 0) ? 1 : v.nok;
    e  = v.first;
    for (int i = 0; i < np; i++) begin
      exp_q.push_back(e);
      e = e + 3'd1;
    end
    pulse_go(v.first, tag);
    if (v.go_mid) begin
      repeat (10) @(negedge clk);
      first = v.first + 3'd3;
      go    = 1'b1;
      @(negedge clk);
      go = 1'b0;
    end
    wait_idle(tag);
    check({tag, "_suma"}, int'(suma), v.suma);
    check({tag, "_maximo"}, int'(maximo), v.maximo);
    check({tag, "_n_ok"}, int'(n_ok), v.nok);
    check({tag, "_done"}, int'(done), int'(v.done));
    check({tag, "_error"}, int'(error), int'(v.err));
    check({tag, "_start_low"}, int'(start), 0);
    check({tag, "_valor_q_empty"}, exp_q.size(), 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{3'd0, M_DELAY, 0, 1'b0, 36, 8, 8, 1'b1, 1'b0};   // basic sweep
    vecs[1] = '{3'd3, M_DELAY, 1, 1'b0, 28, 7, 8, 1'b1, 1'b0};   // wrap over 7->0
    vecs[2] = '{3'd5, M_IMMED, 2, 1'b1, 120, 15, 8, 1'b1, 1'b0}; // fast Fin, go ignored
    vecs[3] = '{3'd2, M_NEVER, 0, 1'b0, 0, 0, 0, 1'b0, 1'b1};    // timeout in REQ
    vecs[4] = '{3'd1, M_HIGH, 2, 1'b0, 15, 15, 1, 1'b0, 1'b1};   // Fin held 1 throughout
    vecs[5] = '{3'd7, M_STUCK, 1, 1'b0, 7, 7, 1, 1'b0, 1'b1};    // Fin stuck after capture
    vecs[6] = '{3'd0, M_DELAY, 0, 1'b0, 36, 8, 8, 1'b1, 1'b0};   // restart after error
    vecs[7] = '{3'd4, M_DELAY, 0, 1'b0, 36, 8, 8, 1'b1, 1'b0};   // used after mid reset

    rst_n  = 1'b0;
    go     = 1'b0;
    first  = 3'd0;
    go4    = 1'b0;
    first4 = 3'd0;
    repeat (2) @(negedge clk);
    check("rst_outputs", int'({valor, start, busy, done, error, suma, maximo, n_ok}), 0);
    check("rst_state", int'(dbg), 0);
    check("rst_outputs4", int'({valor4, start4, busy4, done4, error4, suma4, maximo4, n_ok4}), 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

    // exact timeout: error rises 64 cycles after start rises
    begin
      int c;
      mode = M_NEVER;
      exp_q.push_back(3'd2);
      pulse_go(3'd2, "tmo");
      c = 0;
      while (!error && c < 200) begin
        @(negedge clk);
        c++;
      end
      check("tmo_req_cycles", c, 64);
      check("tmo_start", int'(start), 0);
      check("tmo_busy", int'(busy), 0);
      check("tmo_n_ok", int'(n_ok), 0);
      check("tmo_done", int'(done), 0);
    end

    // wrap-around on the N_VAL=4 instance
    begin
      int c;
      exp4_q.push_back(3'd6);
      exp4_q.push_back(3'd7);
      exp4_q.push_back(3'd0);
      exp4_q.push_back(3'd1);
      @(negedge clk);
      first4 = 3'd6;
      go4    = 1'b1;
      @(negedge clk);
      go4 = 1'b0;
      c = 0;
      while (busy4 && c < 1000) begin
        @(negedge clk);
        c++;
      end
      check("w4_sweep_ends", int'(busy4), 0);
      check("w4_suma", int'(suma4), 14);
      check("w4_maximo", int'(maximo4), 7);
      check("w4_n_ok", int'(n_ok4), 4);
      check("w4_done", int'(done4), 1);
      check("w4_error", int'(error4), 0);
      check("w4_valor_q_empty", exp4_q.size(), 0);
    end

    // asynchronous reset while waiting in REQ
    mode = M_DELAY;
    cfun = 0;
    exp_q.push_back(3'd4);
    pulse_go(3'd4, "rst");
    @(negedge clk);
    check("rst_mid_in_req", int'(dbg), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", int'({valor, start, busy, done, error, suma, maximo, n_ok}), 0);
    check("rst_mid_state", int'(dbg), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(7, vecs[7]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
